// File: rtl/axi64_to_xge64_tx.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : axi64_to_xge64_tx
// Purpose  : AXI-Stream (64b) to XGE MAC packet-port transmit bridge with a
//            2-entry skid FIFO. Optional counters: AXI64_TO_XGE64_TX_STATS_EN.
// Revision : 1.0  initial release
// ============================================================================
module axi64_to_xge64_tx (
   input  logic        xgmii_clk,
   input  logic        xgmii_reset_n,
   input  logic [63:0] tx_axis_tdata,
   input  logic [3:0]  tx_axis_tuser,
   input  logic        tx_axis_tlast,
   input  logic        tx_axis_tvalid,
   output logic        tx_axis_tready,
   output logic [63:0] pkt_tx_data,
   output logic [2:0]  pkt_tx_mod,
   output logic        pkt_tx_sop,
   output logic        pkt_tx_eop,
   output logic        pkt_tx_val,
   input  logic        pkt_tx_full,
   output logic        tx_underrun,
   output logic        tx_err_pulse,
   output logic [31:0] tx_pkt_count,
   output logic [31:0] tx_err_count
);

   localparam logic [0:0] c_IDLE   = 1'b0;
   localparam logic [0:0] c_IN_PKT = 1'b1;

   logic [63:0] r_data [0:1];
   logic [2:0]  r_mod  [0:1];
   logic [1:0]  r_sop;
   logic [1:0]  r_eop;
   logic [1:0]  r_err;
   logic        r_wr_ptr;
   logic        r_rd_ptr;
   logic [1:0]  r_count;
   logic [0:0]  r_state;
   logic        r_in_pkt;
   logic        r_underrun;

   logic        w_full;
   logic        w_empty;
   logic        w_ready;
   logic        w_push;
   logic        w_pop;
   logic        w_head_sop;
   logic        w_head_eop;
   logic        w_head_err;

   assign w_full  = r_count[1];
   assign w_empty = (r_count == 2'd0);
   // Gating with the reset keeps tready low while reset is held, even though the FIFO reads as empty.
   assign w_ready = ~w_full & xgmii_reset_n;
   assign w_push  = tx_axis_tvalid & w_ready;
   assign w_pop   = ~w_empty & ~pkt_tx_full;

   assign w_head_sop = r_sop[r_rd_ptr];
   assign w_head_eop = r_eop[r_rd_ptr];
   assign w_head_err = r_err[r_rd_ptr];

   assign tx_axis_tready = w_ready;
   assign pkt_tx_val     = w_pop;
   assign pkt_tx_data    = w_pop ? r_data[r_rd_ptr] : 64'd0;
   assign pkt_tx_mod     = w_pop ? r_mod[r_rd_ptr]  : 3'd0;
   assign pkt_tx_sop     = w_pop & w_head_sop;
   assign pkt_tx_eop     = w_pop & w_head_eop;
   assign tx_err_pulse   = w_pop & w_head_eop & w_head_err;
   assign tx_underrun    = r_underrun;

   // Payload storage needs no reset: occupancy alone decides what is valid.
   always_ff @(posedge xgmii_clk) begin
      if (w_push) begin
         r_data[r_wr_ptr] <= tx_axis_tdata;
         r_mod[r_wr_ptr]  <= tx_axis_tlast ? tx_axis_tuser[2:0] : 3'd0;
      end
   end

   always_ff @(posedge xgmii_clk or negedge xgmii_reset_n) begin
      if (!xgmii_reset_n) begin
         r_sop <= 2'b00;
         r_eop <= 2'b00;
         r_err <= 2'b00;
      end else if (w_push) begin
         r_sop[r_wr_ptr] <= (r_state == c_IDLE);
         r_eop[r_wr_ptr] <= tx_axis_tlast;
         r_err[r_wr_ptr] <= tx_axis_tuser[3];
      end
   end

   always_ff @(posedge xgmii_clk or negedge xgmii_reset_n) begin
      if (!xgmii_reset_n) begin
         r_wr_ptr <= 1'b0;
         r_rd_ptr <= 1'b0;
         r_count  <= 2'd0;
      end else begin
         if (w_push) r_wr_ptr <= ~r_wr_ptr;
         if (w_pop)  r_rd_ptr <= ~r_rd_ptr;
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + 2'd1;
            2'b01:   r_count <= r_count - 2'd1;
            default: r_count <= r_count;
         endcase
      end
   end

   always_ff @(posedge xgmii_clk or negedge xgmii_reset_n) begin
      if (!xgmii_reset_n) begin
         r_state <= c_IDLE;
      end else if (w_push) begin
         case (r_state)
            c_IDLE:   r_state <= tx_axis_tlast ? c_IDLE : c_IN_PKT;
            c_IN_PKT: r_state <= tx_axis_tlast ? c_IDLE : c_IN_PKT;
            default:  r_state <= c_IDLE;
         endcase
      end
   end

   // Output-side packet tracking: a gap between sop and eop starves the MAC.
   always_ff @(posedge xgmii_clk or negedge xgmii_reset_n) begin
      if (!xgmii_reset_n) begin
         r_in_pkt   <= 1'b0;
         r_underrun <= 1'b0;
      end else begin
         if (w_pop) begin
            if (w_head_eop)      r_in_pkt <= 1'b0;
            else if (w_head_sop) r_in_pkt <= 1'b1;
         end
         if (r_in_pkt && w_empty && !pkt_tx_full) r_underrun <= 1'b1;
      end
   end

`ifdef AXI64_TO_XGE64_TX_STATS_EN
   logic [31:0] r_pkt_count;
   logic [31:0] r_err_count;

   always_ff @(posedge xgmii_clk or negedge xgmii_reset_n) begin
      if (!xgmii_reset_n) begin
         r_pkt_count <= 32'd0;
         r_err_count <= 32'd0;
      end else if (w_pop && w_head_eop) begin
         r_pkt_count <= r_pkt_count + 32'd1;
         if (w_head_err) r_err_count <= r_err_count + 32'd1;
      end
   end

   assign tx_pkt_count = r_pkt_count;
   assign tx_err_count = r_err_count;
`else
   assign tx_pkt_count = 32'd0;
   assign tx_err_count = 32'd0;
`endif

endmodule
`default_nettype wire

// File: doc/axi64_to_xge64_tx.md
AXI64_TO_XGE64_TX -- requirements
Module: axi64_to_xge64_tx

Interface
REQ-001 SHALL have port xgmii_clk, input, 1: sole clock; all state updates on its rising edge.
REQ-002 SHALL have port xgmii_reset_n, input, 1: asynchronous active-low reset.
REQ-003 SHALL have port tx_axis_tdata, input, 64: packet payload, octet 0 in [63:56].
REQ-004 SHALL have port tx_axis_tuser, input, 4: [2:0] valid octets in the tlast beat (0 = all 8 valid); [3] upstream error flag.
REQ-005 SHALL have port tx_axis_tlast, input, 1: last beat of packet.
REQ-006 SHALL have port tx_axis_tvalid, input, 1: upstream beat available.
REQ-007 SHALL have port tx_axis_tready, output, 1: block accepts the beat this cycle.
REQ-008 SHALL have ports pkt_tx_data (output, 64), pkt_tx_mod (output, 3), pkt_tx_sop (output, 1), pkt_tx_eop (output, 1), pkt_tx_val (output, 1), connected to the XGE MAC transmit packet port.
REQ-009 SHALL have port pkt_tx_full, input, 1: MAC transmit FIFO full; no beat may be presented while it is high.
REQ-010 SHALL have port tx_underrun, output, 1: sticky flag for a MAC starvation gap inside a packet.
REQ-011 SHALL have port tx_err_pulse, output, 1: one-cycle pulse when a tlast beat with tuser[3]=1 is forwarded.
REQ-012 SHALL have ports tx_pkt_count and tx_err_count, output, 32 each: statistics counters.

Function
REQ-013 SHALL buffer accepted beats in a 2-entry FIFO holding {data, mod, sop, eop, err}; tx_axis_tready = FIFO not full.
REQ-014 SHALL push on tx_axis_tvalid & tx_axis_tready; SHALL pop when pkt_tx_val is high.
REQ-015 SHALL drive pkt_tx_val = FIFO not empty & ~pkt_tx_full (combinational); pkt_tx_data/mod/sop/eop come from the FIFO head and are gated to 0 when pkt_tx_val is low.
REQ-016 SHALL give 1-cycle latency from an accepted beat to pkt_tx_val when the FIFO was empty and pkt_tx_full is low.
REQ-017 SHALL run an input state machine with states IDLE and IN_PKT: IDLE->IN_PKT on push with tlast=0; IN_PKT->IDLE on push with tlast=1; an IDLE push with tlast=1 stays in IDLE.
REQ-018 SHALL store sop=1 for a beat pushed in IDLE and sop=0 otherwise; a single-beat packet SHALL present sop=1 and eop=1 together.
REQ-019 SHALL store mod=tuser[2:0] for tlast beats and mod=0 for all other beats.
REQ-020 SHALL track an output in-packet flag: set on a popped sop beat without eop, cleared on a popped eop beat.
REQ-021 SHALL set tx_underrun when the in-packet flag is high, the FIFO is empty and pkt_tx_full is low; it clears only on reset.
REQ-022 SHALL assert tx_err_pulse in the cycle an eop beat with err=1 is popped; the data is still forwarded unchanged.
REQ-023 SHALL handle push and pop in the same cycle so that occupancy is unchanged and order is preserved.
REQ-024 SHALL not pop while pkt_tx_full is high; head contents and the FIFO pointers are held.

Reset
REQ-025 SHALL, with xgmii_reset_n low, asynchronously force: FIFO empty, state IDLE, in-packet flag 0, tx_underrun 0, counters 0.
REQ-026 SHALL, as a result of REQ-025, hold tx_axis_tready=0, pkt_tx_val=0, pkt_tx_sop/eop=0, tx_err_pulse=0 during reset.
REQ-027 SHALL, on reset mid-packet, discard the buffered beats and take the next accepted beat after reset as sop.
REQ-028 SHALL release reset with tx_axis_tready=1 in the first cycle after deassertion.

Configuration
REQ-029 SHALL, with macro AXI64_TO_XGE64_TX_STATS_EN defined, increment tx_pkt_count on every popped eop beat and tx_err_count on every popped eop beat with err=1, both wrapping modulo 2^32.
REQ-030 SHALL, with AXI64_TO_XGE64_TX_STATS_EN undefined, tie tx_pkt_count and tx_err_count to constant 0 and implement no counter registers; all other behaviour is unchanged.

Verification
REQ-031 SHALL cover: a 3-beat packet, tdata 0x11..,0x22..,0x33.., tuser=0x5 on the last beat, pkt_tx_full=0 -> sop on beat 1 only, eop with mod=5 on beat 3, each beat 1 cycle after acceptance.
REQ-032 SHALL cover: a single-beat packet with tlast=1, tuser=0 -> one pkt_tx_val cycle with sop=1, eop=1, mod=0.
REQ-033 SHALL cover: pkt_tx_full held high for 4 cycles during a 4-beat packet -> pkt_tx_val=0 for those cycles, tready drops after 2 accepted beats, no data lost or reordered.
REQ-034 SHALL cover: tvalid deasserted for 2 cycles after beat 2 of a 4-beat packet -> tx_underrun=1 and it stays 1 until reset.
REQ-035 SHALL cover: a tlast beat with tuser=0x8, stats enabled -> tx_err_pulse for 1 cycle, tx_err_count=1, tx_pkt_count=1.
REQ-036 SHALL cover: reset pulsed while 2 beats are buffered -> pkt_tx_val=0 immediately; the next beat after reset carries sop=1.
